axi_lite_write_responder: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_wr_addr_decode.sv | 21 ++
 rtl/axi_lite_write_responder.sv | 148 ++++++++++++++
 tb/tb_axi_lite_write_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and write-responder state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'b00,
    WR_HAVE_AW = 2'b01,
    WR_HAVE_W  = 2'b10,
    WR_RESP    = 2'b11
  } wr_state_e;

endpackage

// File: rtl/axi_lite_wr_addr_decode.sv
// Byte address to register word index decode with range check; shared with the read side.
module axi_lite_wr_addr_decode #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range
);

  logic [31:0] word_s;
  logic        unused_s;

  // Bits [1:0] select a byte within the word and play no part in decode.
  assign word_s   = 32'(addr[ADDR_WIDTH-1:2]);
  assign idx      = word_s[IDX_W-1:0];
  assign in_range = (word_s < 32'(NUM_REGS));
  assign unused_s = ^{addr[1:0], word_s[31:IDX_W]};

endmodule

// File: rtl/axi_lite_write_responder.sv
// AXI4-Lite slave write responder: independent AW/W capture, one strobed register write
// per transaction, and B channel generation. Single outstanding transaction.
module axi_lite_write_responder
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [ADDR_WIDTH-1:0]       AWADDR,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [DATA_WIDTH-1:0]       WDATA,
  input  logic [DATA_WIDTH/8-1:0]     WSTRB,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic                        reg_wr_en,
  output logic [$clog2(NUM_REGS)-1:0] reg_wr_idx,
  output logic [DATA_WIDTH-1:0]       reg_wr_data,
  output logic [DATA_WIDTH/8-1:0]     reg_wr_strb
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_e             state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [STRB_W-1:0]     strb_r;

  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  complete_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [STRB_W-1:0]     strb_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  in_range_s;

  assign aw_hs_s = AWVALID & AWREADY;
  assign w_hs_s  = WVALID & WREADY;

  // Whichever channel arrives last supplies its value live; the earlier one comes from the hold register.
  assign addr_s = (state_r == WR_HAVE_AW) ? addr_r : AWADDR;
  assign data_s = (state_r == WR_HAVE_W)  ? data_r : WDATA;
  assign strb_s = (state_r == WR_HAVE_W)  ? strb_r : WSTRB;

  assign complete_s = ((state_r == WR_IDLE)    & aw_hs_s & w_hs_s) |
                      ((state_r == WR_HAVE_AW) & w_hs_s) |
                      ((state_r == WR_HAVE_W)  & aw_hs_s);

  axi_lite_wr_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr     (addr_s),
    .idx      (idx_s),
    .in_range (in_range_s)
  );

  // Transaction FSM with all channel and register-port outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r     <= WR_IDLE;
      addr_r      <= '0;
      data_r      <= '0;
      strb_r      <= '0;
      AWREADY     <= 1'b0;
      WREADY      <= 1'b0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
      reg_wr_en   <= 1'b0;
      reg_wr_idx  <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      if (complete_s) begin
        state_r   <= WR_RESP;
        AWREADY   <= 1'b0;
        WREADY    <= 1'b0;
        BVALID    <= 1'b1;
        BRESP     <= in_range_s ? RESP_OKAY : RESP_SLVERR;
        reg_wr_en <= in_range_s;
        if (in_range_s) begin
          reg_wr_idx  <= idx_s;
          reg_wr_data <= data_s;
          reg_wr_strb <= strb_s;
        end else begin
          reg_wr_idx  <= reg_wr_idx;
        end
      end else begin
        case (state_r)
          WR_IDLE: begin
            if (aw_hs_s) begin
              addr_r  <= AWADDR;
              state_r <= WR_HAVE_AW;
              AWREADY <= 1'b0;
              WREADY  <= 1'b1;
            end else if (w_hs_s) begin
              data_r  <= WDATA;
              strb_r  <= WSTRB;
              state_r <= WR_HAVE_W;
              AWREADY <= 1'b1;
              WREADY  <= 1'b0;
            end else begin
              AWREADY <= 1'b1;
              WREADY  <= 1'b1;
            end
          end
          WR_HAVE_AW: begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
          end
          WR_HAVE_W: begin
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
          end
          WR_RESP: begin
            if (BREADY) begin
              state_r <= WR_IDLE;
              BVALID  <= 1'b0;
              BRESP   <= RESP_OKAY;
              AWREADY <= 1'b1;
              WREADY  <= 1'b1;
            end else begin
              BVALID  <= 1'b1;
            end
          end
          default: begin
            state_r <= WR_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_write_responder.sv
// Directed bench for axi_lite_write_responder: stimulus pushes expected B/register writes into
// queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_lite_write_responder;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [7:0]  AWADDR = 8'h00;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = 32'h0;
  logic [3:0]  WSTRB = 4'h0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;

  int   checks = 0;
  int   failures = 0;
  int   wr_seen = 0;
  int   b_seen = 0;
  wr_t  wq[$];
  logic [1:0] bq[$];
  wr_t  w_m;
  logic [1:0] b_m;

  axi_lite_write_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx),
    .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [5:0] word;
    wr_t e;
    word = addr[7:2];
    if (word < 6'd16) begin
      e.idx  = word[3:0];
      e.data = data;
      e.strb = strb;
      wq.push_back(e);
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin
      tick();
      n++;
    end
    chk("ready_timeout", {31'd0, AWREADY && WREADY}, 32'd1);
  endtask

  // AW and W presented together; returns #1 after the handshake edge.
  task automatic sim_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wait_ready();
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    push_exp(addr, data, strb);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (reg_wr_en) begin
        wr_seen++;
        chk("wr_with_bvalid", {31'd0, BVALID}, 32'd1);
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wr actual=idx%0d expected=none", reg_wr_idx);
        end else begin
          w_m = wq.pop_front();
          chk("wr_idx", {28'd0, reg_wr_idx}, {28'd0, w_m.idx});
          chk("wr_data", reg_wr_data, w_m.data);
          chk("wr_strb", {28'd0, reg_wr_strb}, {28'd0, w_m.strb});
        end
      end
      if (BVALID && BREADY) begin
        b_seen++;
        if (bq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_b actual=resp%0d expected=none", BRESP);
        end else begin
          b_m = bq.pop_front();
          chk("bresp", {30'd0, BRESP}, {30'd0, b_m});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    #22;
    chk("rst_outputs", {AWREADY, WREADY, BVALID, BRESP, reg_wr_en, reg_wr_idx, reg_wr_strb},
        32'd0);
    chk("rst_data", reg_wr_data, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    tick();
    chk("first_edge_readies", {30'd0, AWREADY, WREADY}, 32'd3);

    // Simultaneous AW/W.
    BREADY = 1'b1;
    sim_write(8'h08, 32'hDEADBEEF, 4'hF);
    chk("sim_bvalid", {31'd0, BVALID}, 32'd1);
    chk("sim_wr_en", {31'd0, reg_wr_en}, 32'd1);
    chk("sim_readies_low", {30'd0, AWREADY, WREADY}, 32'd0);
    tick();
    chk("sim_bvalid_drop", {31'd0, BVALID}, 32'd0);
    chk("sim_readies_back", {30'd0, AWREADY, WREADY}, 32'd3);

    // Address first, data three cycles later.
    AWADDR = 8'h04; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("awfirst_awready", {31'd0, AWREADY}, 32'd0);
      chk("awfirst_wready", {31'd0, WREADY}, 32'd1);
      chk("awfirst_nob", {31'd0, BVALID}, 32'd0);
      if (k < 2) tick();
    end
    WDATA = 32'h12345678; WSTRB = 4'h3; WVALID = 1'b1;
    push_exp(8'h04, 32'h12345678, 4'h3);
    tick();
    WVALID = 1'b0;
    chk("awfirst_bvalid", {31'd0, BVALID}, 32'd1);
    chk("awfirst_bresp", {30'd0, BRESP}, 32'd0);
    tick();

    // Data first, address three cycles later.
    wait_ready();
    WDATA = 32'h12345678; WSTRB = 4'h3; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("wfirst_wready", {31'd0, WREADY}, 32'd0);
      chk("wfirst_awready", {31'd0, AWREADY}, 32'd1);
      if (k < 2) tick();
    end
    AWADDR = 8'h04; AWVALID = 1'b1;
    push_exp(8'h04, 32'h12345678, 4'h3);
    tick();
    AWVALID = 1'b0;
    chk("wfirst_bvalid", {31'd0, BVALID}, 32'd1);
    tick();

    // Out of range: word 16 of 16.
    sim_write(8'h40, 32'hA5A5A5A5, 4'hF);
    chk("oor_bresp", {30'd0, BRESP}, 32'd2);
    chk("oor_no_wr", {31'd0, reg_wr_en}, 32'd0);
    tick();

    // Zero strobe still writes with OKAY.
    sim_write(8'h3C, 32'h0BADF00D, 4'h0);
    chk("zstrb_bresp", {30'd0, BRESP}, 32'd0);
    tick();

    // B backpressure: six BVALID cycles, new AW ignored.
    BREADY = 1'b0;
    sim_write(8'h10, 32'h01020304, 4'hC);
    for (int k = 0; k < 6; k++) begin
      chk("bp_bvalid", {31'd0, BVALID}, 32'd1);
      chk("bp_bresp", {30'd0, BRESP}, 32'd0);
      chk("bp_readies", {30'd0, AWREADY, WREADY}, 32'd0);
      AWADDR = 8'h14;
      AWVALID = (k >= 1 && k <= 3);
      if (k == 5) BREADY = 1'b1;
      tick();
    end
    AWVALID = 1'b0;
    chk("bp_done", {31'd0, BVALID}, 32'd0);
    chk("bp_readies_back", {30'd0, AWREADY, WREADY}, 32'd3);

    // Reset while holding an address.
    AWADDR = 8'h08; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("midrst_have_aw", {30'd0, AWREADY, WREADY}, 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    chk("midrst_outputs", {AWREADY, WREADY, BVALID, BRESP, reg_wr_en}, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    tick();
    chk("midrst_readies", {30'd0, AWREADY, WREADY}, 32'd3);
    sim_write(8'h0C, 32'hCAFEF00D, 4'hF);
    chk("midrst_bvalid", {31'd0, BVALID}, 32'd1);
    tick();

    // Back-to-back with BREADY high: handshake every second edge.
    wr0 = wr_seen;
    BREADY = 1'b1;
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      AWADDR = 8'(4 * (i + 4));
      WDATA = 32'h1000_0000 + 32'(i);
      WSTRB = 4'(i + 1);
      AWVALID = 1'b1; WVALID = 1'b1;
      push_exp(AWADDR, WDATA, WSTRB);
      tick();
      chk("b2b_bvalid", {31'd0, BVALID}, 32'd1);
      if (i == 3) begin
        AWVALID = 1'b0; WVALID = 1'b0;
      end
      tick();
      chk("b2b_ready_after_b", {29'd0, BVALID, AWREADY, WREADY}, 32'd3);
    end
    tick();
    chk("b2b_writes", 32'(wr_seen - wr0), 32'd4);

    repeat (3) tick();
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("b_total", 32'(b_seen), 32'd11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
